cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the RV32IM core. It replaces the free-running 2-bit phase counter with a handshaked FSM (fetch, execute, mem, writeback) that stalls on instruction fetch, multi-cycle mul/div and MMIO load/store. It owns the PC, the retired-instruction counter and the writeback strobe, and halts with an error code on bus timeout or a misaligned jump target. It sits between the decoder/branch unit and the register file, ALU and MMIO blocks.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 255, max wait cycles for any handshake before halting (1..65535)

Ports:
CLK100MHZ  in  1  system clock
rst  in  1  synchronous active-high reset
fetch_req  out  1  level request to MMIO for the instruction at pc
instr_valid  in  1  instruction word valid (fetch done)
is_load  in  1  decoded load
is_store  in  1  decoded store
is_muldiv  in  1  decoded mul/div/rem (multi-cycle ALU op)
rd_en  in  1  decoded destination-register write enable
taken_branch  in  1  branch/jump taken
target  in  32  branch/jump target address
alu_start  out  1  one-cycle start pulse to multi-cycle ALU
alu_done  in  1  multi-cycle ALU result valid
mem_req  out  1  one-cycle load/store request pulse to MMIO
mem_done  in  1  MMIO load/store complete
stage  out  2  0 fetch, 1 exec, 2 mem, 3 wb; drives rf/csr_rf phase input
rf_we  out  1  register-file write strobe
retire  out  1  one-cycle pulse per retired instruction
pc  out  32  current program counter
instret  out  32  retired-instruction count (feeds CSR instret)
halted  out  1  sequencer stopped
err_code  out  2  0 none, 1 handshake timeout, 2 misaligned target

Behaviour:
- Reset (any cycle, including mid-wait): state FETCH, pc=RESET_PC, instret=0, wait counter=0, halted=0, err_code=0; alu_start, mem_req, rf_we, retire=0. fetch_req rises the cycle after rst deasserts.
- FETCH (stage=0): fetch_req=1. instr_valid=1 -> EXEC next cycle. Minimum latency is 1 cycle.
- EXEC (stage=1): if is_muldiv, alu_start=1 on the entry cycle only; stay until alu_done (alu_done on the entry cycle is accepted). Non-muldiv: exactly 1 cycle. Exit to MEM if is_load|is_store, else WB.
- MEM (stage=2): mem_req=1 on the entry cycle only; stay until mem_done (accepted from the entry cycle). Exit to WB.
- WB (stage=3): exactly 1 cycle.
  - taken_branch=0: pc<=pc+4 (mod 2^32, wraps at 0xFFFF_FFFC->0).
  - taken_branch=1 with target[1:0]==0: pc<=target.
  - taken_branch=1 with target[1:0]!=0: pc unchanged, rf_we=0, retire=0, instret unchanged; HALT with err_code=2.
  - Otherwise: rf_we=rd_en, retire=1, instret<=instret+1 (wraps 0xFFFF_FFFF->0). Next state FETCH.
- Wait counter: cleared on every state entry; increments each cycle that FETCH/EXEC(muldiv)/MEM waits without its done signal. If the counter reaches TIMEOUT with done still low, go to HALT with err_code=1. A done arriving in the same cycle as the limit wins (no error).
- HALT: stage=0, all request/strobe outputs 0, halted=1, pc/instret/err_code frozen; leaves only via rst.
- Done inputs arriving in a state that does not expect them are ignored. No strobe ever lasts more than 1 cycle.
- pc, instret, stage, halted and err_code are registered outputs. The other outputs decode the current state only.

Test Plan:
- Reset then ADDI stream, instr_valid tied 1, rd_en=1 -> each instruction takes 3 cycles (F,E,W); pc 0,4,8; retire/rf_we pulse in stage 3; instret=3 after 9 cycles.
- LW with mem_done 4 cycles after mem_req -> stage sequence 0,1,2,2,2,2,2,3; mem_req high exactly 1 cycle; pc+4 after WB.
- DIV with alu_done after 33 cycles, then taken JAL target=0x100 -> single alu_start pulse; pc=0x100 after the JAL WB; instret +2.
- Taken branch target=0x102 -> halted=1, err_code=2, pc holds the branch address, retire=0, instret unchanged; rst -> pc=RESET_PC, err_code=0.
- TIMEOUT=8, mem_done never asserted on SW -> halt after 8 wait cycles, err_code=1; mem_done on the 8th cycle instead -> no error, WB proceeds.
- rst asserted mid-MEM wait, pc=0xFFFF_FFFC wrap case -> next cycle FETCH, pc=RESET_PC, mem_req=0; separately pc 0xFFFF_FFFC +4 -> 0.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle RV32IM sequencer: handshaked fetch/exec/mem/writeback FSM that owns
// the PC, the retired-instruction count and the writeback strobe, and halts on faults.
module cpu_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  output logic        fetch_req,
  input  logic        instr_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_muldiv,
  input  logic        rd_en,
  input  logic        taken_branch,
  input  logic [31:0] target,
  output logic        alu_start,
  input  logic        alu_done,
  output logic        mem_req,
  input  logic        mem_done,
  output logic [1:0]  stage,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  err_code
);
  // EXEC/MEM are split into entry and wait states so the start pulses last one cycle.
  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_EXEC_WAIT, S_MEM, S_MEM_WAIT, S_WB, S_HALT
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        misaligned;
  logic        mem_op;
  logic        waiting;
  logic        done;

  assign misaligned = taken_branch && (target[1:0] != 2'b00);
  assign mem_op     = is_load || is_store;

  always_comb begin
    waiting = 1'b0;
    done    = 1'b0;
    case (state)
      S_FETCH: begin
        waiting = 1'b1;
        done    = instr_valid;
      end
      S_EXEC: begin
        waiting = is_muldiv;
        done    = alu_done;
      end
      S_EXEC_WAIT: begin
        waiting = 1'b1;
        done    = alu_done;
      end
      S_MEM, S_MEM_WAIT: begin
        waiting = 1'b1;
        done    = mem_done;
      end
      default: ;
    endcase
  end

  assign fetch_req = !rst && (state == S_FETCH);
  assign alu_start = !rst && (state == S_EXEC) && is_muldiv;
  assign mem_req   = !rst && (state == S_MEM);
  assign retire    = !rst && (state == S_WB) && !misaligned;
  assign rf_we     = retire && rd_en;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state    <= S_FETCH;
      stage    <= 2'd0;
      pc       <= RESET_PC;
      instret  <= '0;
      wait_cnt <= '0;
      halted   <= 1'b0;
      err_code <= 2'd0;
    end else if (waiting && !done) begin
      // A done arriving on the limit cycle takes the other branch, so it wins.
      if (wait_cnt == WAIT_LAST) begin
        state    <= S_HALT;
        stage    <= 2'd0;
        halted   <= 1'b1;
        err_code <= 2'd1;
      end else begin
        wait_cnt <= wait_cnt + 16'd1;
        if (state == S_EXEC) state <= S_EXEC_WAIT;
        if (state == S_MEM)  state <= S_MEM_WAIT;
      end
    end else begin
      case (state)
        S_FETCH: begin
          state    <= S_EXEC;
          stage    <= 2'd1;
          wait_cnt <= '0;
        end
        S_EXEC, S_EXEC_WAIT: begin
          wait_cnt <= '0;
          if (mem_op) begin
            state <= S_MEM;
            stage <= 2'd2;
          end else begin
            state <= S_WB;
            stage <= 2'd3;
          end
        end
        S_MEM, S_MEM_WAIT: begin
          state    <= S_WB;
          stage    <= 2'd3;
          wait_cnt <= '0;
        end
        S_WB: begin
          wait_cnt <= '0;
          if (misaligned) begin
            state    <= S_HALT;
            stage    <= 2'd0;
            halted   <= 1'b1;
            err_code <= 2'd2;
          end else begin
            state   <= S_FETCH;
            stage   <= 2'd0;
            pc      <= taken_branch ? target : pc + 32'd4;
            instret <= instret + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: per-instruction expected stage/strobe traces built from
// handshake latencies, plus a PC/instret/halt model, under randomized stimulus.
module tb_cpu_seq_ctrl;
  localparam logic [31:0] RPC = 32'h0000_0040;
  localparam int TO = 40;

  logic        CLK100MHZ = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req, instr_valid = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic        is_muldiv = 1'b0, rd_en = 1'b0, taken_branch = 1'b0;
  logic [31:0] target = '0;
  logic        alu_start, alu_done = 1'b0, mem_req, mem_done = 1'b0;
  logic [1:0]  stage;
  logic        rf_we, retire;
  logic [31:0] pc, instret;
  logic        halted;
  logic [1:0]  err_code;

  cpu_seq_ctrl #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .fetch_req(fetch_req), .instr_valid(instr_valid),
    .is_load(is_load), .is_store(is_store), .is_muldiv(is_muldiv), .rd_en(rd_en),
    .taken_branch(taken_branch), .target(target), .alu_start(alu_start),
    .alu_done(alu_done), .mem_req(mem_req), .mem_done(mem_done), .stage(stage),
    .rf_we(rf_we), .retire(retire), .pc(pc), .instret(instret), .halted(halted),
    .err_code(err_code)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int total = 0;
  int bad = 0;
  logic [31:0] m_pc, m_instret;
  logic        m_halted;
  logic [1:0]  m_err;

  // Expected per-cycle trace of one instruction plus the done inputs to drive.
  int q_stg[$];
  bit q_iv[$], q_ad[$], q_md[$], q_fr[$], q_as[$], q_mr[$], q_wb[$];

  // kind: 0 fetch, 1 muldiv exec, 2 mem access, 3 single-cycle exec/wb.
  // Returns 1 when the handshake latency exceeds the timeout window.
  function automatic bit add_phase(input int stg, input int lat, input int kind);
    int n;
    n = (lat >= TO) ? TO : lat + 1;
    for (int i = 0; i < n; i++) begin
      q_stg.push_back(stg);
      q_iv.push_back((kind == 0) ? (i == lat) : bit'($urandom_range(0, 1)));
      q_ad.push_back((kind == 1) ? (i == lat) : bit'($urandom_range(0, 1)));
      q_md.push_back((kind == 2) ? (i == lat) : bit'($urandom_range(0, 1)));
      q_fr.push_back(kind == 0);
      q_as.push_back(kind == 1 && i == 0);
      q_mr.push_back(kind == 2 && i == 0);
      q_wb.push_back(stg == 3);
    end
    return lat >= TO;
  endfunction

  task automatic test_reset(input string name);
    rst = 1'b1;
    instr_valid = 1'($urandom); alu_done = 1'($urandom); mem_done = 1'($urandom);
    is_muldiv = 1'($urandom); is_load = 1'($urandom); taken_branch = 1'b0;
    repeat (2) begin @(posedge CLK100MHZ); #1; end
    @(negedge CLK100MHZ);
    total += 6;
    if (fetch_req !== 1'b0) begin bad++; $display("FAIL %s fetch_req got=%b want=0", name, fetch_req); end
    if ({alu_start, mem_req, rf_we, retire} !== 4'b0) begin bad++; $display("FAIL %s strobes got=%b want=0000", name, {alu_start, mem_req, rf_we, retire}); end
    if (pc !== RPC) begin bad++; $display("FAIL %s pc got=%h want=%h", name, pc, RPC); end
    if (instret !== 32'd0) begin bad++; $display("FAIL %s instret got=%0d want=0", name, instret); end
    if (stage !== 2'd0 || halted !== 1'b0) begin bad++; $display("FAIL %s stage/halted got=%0d/%b want=0/0", name, stage, halted); end
    if (err_code !== 2'd0) begin bad++; $display("FAIL %s err_code got=%0d want=0", name, err_code); end
    @(posedge CLK100MHZ); #1;
    rst = 1'b0;
    m_pc = RPC; m_instret = '0; m_halted = 1'b0; m_err = 2'd0;
  endtask

  task automatic run_instr(input int fl, input bit md, input int al, input bit ld,
                           input bit st, input int ml, input bit rd, input bit tkn,
                           input logic [31:0] tgt, input int abort, input string name);
    bit to, mis, aborted;
    q_stg.delete(); q_iv.delete(); q_ad.delete(); q_md.delete();
    q_fr.delete(); q_as.delete(); q_mr.delete(); q_wb.delete();
    is_muldiv = md; is_load = ld; is_store = st; rd_en = rd;
    taken_branch = tkn; target = tgt;
    mis = tkn && (tgt[1:0] != 2'b00);
    to = add_phase(0, fl, 0);
    if (!to) to = md ? add_phase(1, al, 1) : add_phase(1, 0, 3);
    if (!to && (ld || st)) to = add_phase(2, ml, 2);
    if (!to) void'(add_phase(3, 0, 3));
    aborted = 1'b0;
    for (int c = 0; c < q_stg.size(); c++) begin
      instr_valid = q_iv[c]; alu_done = q_ad[c]; mem_done = q_md[c];
      if (c == abort) begin
        rst = 1'b1;
        @(posedge CLK100MHZ); #1;
        rst = 1'b0; instr_valid = 1'b0; alu_done = 1'b0; mem_done = 1'b0;
        m_pc = RPC; m_instret = '0; m_halted = 1'b0; m_err = 2'd0;
        @(negedge CLK100MHZ);
        total += 4;
        if (stage !== 2'd0) begin bad++; $display("FAIL %s abort stage got=%0d want=0", name, stage); end
        if (fetch_req !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL %s abort fetch_req/mem_req got=%b/%b want=1/0", name, fetch_req, mem_req); end
        if (pc !== RPC) begin bad++; $display("FAIL %s abort pc got=%h want=%h", name, pc, RPC); end
        if (instret !== 32'd0 || halted !== 1'b0) begin bad++; $display("FAIL %s abort instret/halted got=%0d/%b want=0/0", name, instret, halted); end
        @(posedge CLK100MHZ); #1;
        aborted = 1'b1;
        break;
      end
      @(negedge CLK100MHZ);
      total += 9;
      if (stage !== 2'(q_stg[c])) begin bad++; $display("FAIL %s stage cyc=%0d got=%0d want=%0d", name, c, stage, q_stg[c]); end
      if (fetch_req !== q_fr[c]) begin bad++; $display("FAIL %s fetch_req cyc=%0d got=%b want=%b", name, c, fetch_req, q_fr[c]); end
      if (alu_start !== q_as[c]) begin bad++; $display("FAIL %s alu_start cyc=%0d got=%b want=%b", name, c, alu_start, q_as[c]); end
      if (mem_req !== q_mr[c]) begin bad++; $display("FAIL %s mem_req cyc=%0d got=%b want=%b", name, c, mem_req, q_mr[c]); end
      if (rf_we !== (q_wb[c] && !mis && rd)) begin bad++; $display("FAIL %s rf_we cyc=%0d got=%b want=%b", name, c, rf_we, q_wb[c] && !mis && rd); end
      if (retire !== (q_wb[c] && !mis)) begin bad++; $display("FAIL %s retire cyc=%0d got=%b want=%b", name, c, retire, q_wb[c] && !mis); end
      if (pc !== m_pc) begin bad++; $display("FAIL %s pc cyc=%0d got=%h want=%h", name, c, pc, m_pc); end
      if (instret !== m_instret) begin bad++; $display("FAIL %s instret cyc=%0d got=%0d want=%0d", name, c, instret, m_instret); end
      if (halted !== 1'b0 || err_code !== 2'd0) begin bad++; $display("FAIL %s halted/err cyc=%0d got=%b/%0d want=0/0", name, c, halted, err_code); end
      @(posedge CLK100MHZ); #1;
    end
    if (!aborted) begin
      if (to) begin
        m_halted = 1'b1; m_err = 2'd1;
      end else if (mis) begin
        m_halted = 1'b1; m_err = 2'd2;
      end else begin
        m_pc = tkn ? tgt : m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
      end
    end
  endtask

  task automatic check_halt(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      instr_valid = 1'($urandom); alu_done = 1'($urandom); mem_done = 1'($urandom);
      is_muldiv = 1'($urandom); is_load = 1'($urandom); rd_en = 1'b1;
      taken_branch = 1'($urandom); target = $urandom & 32'hFFFF_FFFC;
      @(negedge CLK100MHZ);
      total += 5;
      if (halted !== 1'b1) begin bad++; $display("FAIL %s halted cyc=%0d got=%b want=1", name, c, halted); end
      if (err_code !== m_err) begin bad++; $display("FAIL %s err_code cyc=%0d got=%0d want=%0d", name, c, err_code, m_err); end
      if (stage !== 2'd0) begin bad++; $display("FAIL %s stage cyc=%0d got=%0d want=0", name, c, stage); end
      if ({fetch_req, alu_start, mem_req, rf_we, retire} !== 5'b0) begin bad++; $display("FAIL %s strobes cyc=%0d got=%b want=00000", name, c, {fetch_req, alu_start, mem_req, rf_we, retire}); end
      if (pc !== m_pc || instret !== m_instret) begin bad++; $display("FAIL %s frozen pc/instret got=%h/%0d want=%h/%0d", name, pc, instret, m_pc, m_instret); end
      @(posedge CLK100MHZ); #1;
    end
  endtask

  task automatic test_addi_stream();
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 0, 1, 0, '0, -1, "addi");
    total++;
    if (instret !== 32'd3 || pc !== RPC + 32'd12) begin
      bad++; $display("FAIL addi_end instret/pc got=%0d/%h want=3/%h", instret, pc, RPC + 32'd12);
    end
  endtask

  task automatic test_load();
    run_instr(1, 0, 0, 1, 0, 4, 1, 0, '0, -1, "lw");
    run_instr(0, 0, 0, 0, 1, 0, 0, 0, '0, -1, "sw_fast");
  endtask

  task automatic test_div_jal();
    run_instr(0, 1, 33, 0, 0, 0, 1, 0, '0, -1, "div");
    run_instr(2, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0100, -1, "jal");
    run_instr(0, 1, 0, 0, 0, 0, 1, 0, '0, -1, "mul_fast");
  endtask

  task automatic test_misaligned();
    run_instr(0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0102, -1, "misaligned");
    check_halt(4, "misaligned_halt");
    test_reset("reset_after_misaligned");
  endtask

  task automatic test_timeout();
    run_instr(0, 0, 0, 0, 1, TO + 10, 1, 0, '0, -1, "sw_timeout");
    check_halt(3, "sw_timeout_halt");
    test_reset("reset_after_sw_timeout");
    run_instr(0, 0, 0, 0, 1, TO - 1, 1, 0, '0, -1, "sw_done_at_limit");
    run_instr(TO - 1, 1, TO - 1, 0, 0, 0, 1, 0, '0, -1, "fetch_div_at_limit");
    run_instr(TO, 0, 0, 0, 0, 0, 1, 0, '0, -1, "fetch_timeout");
    check_halt(2, "fetch_timeout_halt");
    test_reset("reset_after_fetch_timeout");
    run_instr(0, 1, TO + 3, 0, 0, 0, 1, 0, '0, -1, "div_timeout");
    check_halt(2, "div_timeout_halt");
    test_reset("reset_after_div_timeout");
  endtask

  task automatic test_wrap();
    run_instr(0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, -1, "jal_top");
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, '0, -1, "addi_wrap");
    total++;
    if (pc !== 32'd0) begin bad++; $display("FAIL pc_wrap got=%h want=00000000", pc); end
    run_instr(0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, -1, "jal_top2");
    run_instr(0, 0, 0, 1, 0, 20, 1, 0, '0, 3, "lw_reset_mid_wait");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int op;
      bit tkn;
      op  = $urandom_range(0, 3);
      tkn = ($urandom_range(0, 3) == 0);
      run_instr($urandom_range(0, 3), op == 1, $urandom_range(0, 5), op == 2, op == 3,
                $urandom_range(0, 5), 1'($urandom), tkn, $urandom & 32'hFFFF_FFFC, -1, "random");
    end
  endtask

  initial begin
    test_reset("reset");
    test_addi_stream();
    test_load();
    test_div_jal();
    test_misaligned();
    test_timeout();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
